// File: rtl/dna_csr_pkg.sv
// Shared definitions for the DNA CSR bank: register word offsets, CTRL/STATUS
// bit positions, FSM states and the byte-strobe merge helper.
package dna_csr_pkg;

   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_STATUS = 3'd1;
   localparam logic [2:0] REG_SRC    = 3'd2;
   localparam logic [2:0] REG_DST    = 3'd3;
   localparam logic [2:0] REG_LEN    = 3'd4;
   localparam logic [2:0] REG_RESULT = 3'd5;
   localparam logic [2:0] REG_ID     = 3'd6;
   localparam logic [2:0] REG_PERF   = 3'd7;

   localparam int CTRL_START     = 0;
   localparam int CTRL_IRQ_EN    = 1;
   localparam int CTRL_SOFT_RST  = 2;

   localparam int STAT_BUSY      = 0;
   localparam int STAT_DONE      = 1;
   localparam int STAT_ERR       = 2;
   localparam int STAT_START_OVR = 3;

   localparam logic [31:0] DNA_ID_DEFAULT = 32'h444E_4101;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   function automatic logic [31:0] apply_strobe(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  wen);
      logic [31:0] merged;
      merged = old_val;
      for (int k = 0; k < 4; k++) begin
         if (wen[k]) merged[8*k +: 8] = new_val[8*k +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/dna_csr_perf_counter.sv
// Saturating 32-bit cycle counter; synchronous clear has priority over counting.
module dna_csr_perf_counter (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        clr,
   output logic [31:0] cnt
);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != 32'hFFFF_FFFF)) begin
         cnt <= cnt + 32'd1;
      end
   end

endmodule

// File: rtl/dna_csr_regfile.sv
// DNA engine CSR bank: byte-strobed writes, zero-latency read mux, job FSM, sticky status and irq.
// Optional PERF run-cycle counter is built when DNA_CSR_PERF_CNT_EN is defined.
module dna_csr_regfile
   import dna_csr_pkg::*;
#(
   parameter int          ADDR_WIDTH = 32,
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] ID_VALUE   = DNA_ID_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            i_wen,
   input  logic [ADDR_WIDTH-1:0] i_addr_w,
   input  logic [DATA_WIDTH-1:0] i_data_w,
   input  logic [ADDR_WIDTH-1:0] i_addr_r,
   output logic [DATA_WIDTH-1:0] o_data_r,
   output logic                  o_start,
   output logic                  o_soft_rst,
   output logic [31:0]           o_src_addr,
   output logic [31:0]           o_dst_addr,
   output logic [31:0]           o_length,
   input  logic                  i_done,
   input  logic                  i_err,
   input  logic [31:0]           i_result,
   output logic                  o_busy,
   output logic                  o_irq
);

   state_t      state_q, state_d;
   logic [31:0] src_q, dst_q, len_q, result_q, perf_cnt;
   logic        irq_en_q, irq_en_d;
   logic [3:1]  sticky_q, sticky_d, sticky_clr;
   logic        start_d, done_set, err_set, ovr_set, result_ld;

   logic [2:0]  waddr, raddr;
   logic        wr, wr_ctrl_b0, start_wr, soft_wr;
   logic        unused_addr_bits;

   assign waddr      = i_addr_w[4:2];
   assign raddr      = i_addr_r[4:2];
   assign wr         = |i_wen;
   assign wr_ctrl_b0 = wr && (waddr == REG_CTRL) && i_wen[0];
   assign start_wr   = wr_ctrl_b0 && i_data_w[CTRL_START];
   assign soft_wr    = wr_ctrl_b0 && i_data_w[CTRL_SOFT_RST];
   // Registers alias every 32 bytes, so the remaining address bits are don't-care.
   assign unused_addr_bits = ^{i_addr_w, i_addr_r};

   always_comb begin
      state_d   = state_q;
      start_d   = 1'b0;
      done_set  = 1'b0;
      err_set   = 1'b0;
      ovr_set   = 1'b0;
      result_ld = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_wr && !soft_wr) begin
               if (len_q != 32'd0) begin
                  start_d = 1'b1;
                  state_d = RUN;
               end else begin
                  state_d = FIN;
               end
            end
         end
         RUN: begin
            ovr_set = start_wr && !soft_wr;
            if (i_err) begin
               err_set = 1'b1;
               state_d = FIN;
            end else if (i_done) begin
               result_ld = 1'b1;
               state_d   = FIN;
            end
         end
         FIN: begin
            ovr_set  = start_wr && !soft_wr;
            done_set = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Completion or error with no job in flight is a protocol error from the engine.
      if ((state_q != RUN) && (i_done || i_err)) err_set = 1'b1;
      if (soft_wr) state_d = IDLE;
   end

   assign sticky_clr = (wr && (waddr == REG_STATUS) && i_wen[0]) ? i_data_w[3:1] : 3'b000;
   // Set events are OR-ed after the clear so a same-cycle set survives a W1C.
   assign sticky_d   = (sticky_q & ~sticky_clr) | {ovr_set, err_set, done_set};
   assign irq_en_d   = wr_ctrl_b0 ? i_data_w[CTRL_IRQ_EN] : irq_en_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         result_q   <= '0;
         irq_en_q   <= 1'b0;
         sticky_q   <= '0;
         o_start    <= 1'b0;
         o_soft_rst <= 1'b0;
         o_irq      <= 1'b0;
      end else begin
         state_q    <= state_d;
         irq_en_q   <= irq_en_d;
         sticky_q   <= sticky_d;
         o_start    <= start_d;
         o_soft_rst <= soft_wr;
         o_irq      <= irq_en_d && (|sticky_d);
         if (result_ld) result_q <= i_result;
         if (wr && (waddr == REG_SRC)) src_q <= apply_strobe(src_q, i_data_w, i_wen);
         if (wr && (waddr == REG_DST)) dst_q <= apply_strobe(dst_q, i_data_w, i_wen);
         if (wr && (waddr == REG_LEN)) len_q <= apply_strobe(len_q, i_data_w, i_wen);
      end
   end

`ifdef DNA_CSR_PERF_CNT_EN
   logic perf_clr;
   assign perf_clr = start_d || (wr && (waddr == REG_PERF));

   dna_csr_perf_counter u_perf (
      .clk   (clk),
      .reset (reset),
      .en    (state_q == RUN),
      .clr   (perf_clr),
      .cnt   (perf_cnt)
   );
`else
   assign perf_cnt = '0;
`endif

   always_comb begin
      o_data_r = '0;
      case (raddr)
         REG_CTRL:   o_data_r[CTRL_IRQ_EN] = irq_en_q;
         REG_STATUS: o_data_r[3:0] = {sticky_q, state_q == RUN};
         REG_SRC:    o_data_r = src_q;
         REG_DST:    o_data_r = dst_q;
         REG_LEN:    o_data_r = len_q;
         REG_RESULT: o_data_r = result_q;
         REG_ID:     o_data_r = ID_VALUE;
         REG_PERF:   o_data_r = perf_cnt;
         default:    o_data_r = '0;
      endcase
   end

   assign o_busy     = (state_q == RUN);
   assign o_src_addr = src_q;
   assign o_dst_addr = dst_q;
   assign o_length   = len_q;

endmodule

// File: tb/tb_dna_csr_regfile.sv
// Directed bench for dna_csr_regfile; expectations are queued by the stimulus
// and compared by a negedge monitor.
module tb_dna_csr_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  i_wen;
   logic [31:0] i_addr_w, i_data_w, i_addr_r, o_data_r;
   logic        o_start, o_soft_rst, i_done, i_err, o_busy, o_irq;
   logic [31:0] o_src_addr, o_dst_addr, o_length, i_result;

`ifdef DNA_CSR_PERF_CNT_EN
   localparam logic [31:0] PERF_EXP = 32'd10;
`else
   localparam logic [31:0] PERF_EXP = 32'd0;
`endif

   localparam logic [3:0] S_RD = 4'd0, S_START = 4'd1, S_SOFT = 4'd2, S_BUSY = 4'd3,
                          S_IRQ = 4'd4, S_SRC = 4'd5, S_LEN = 4'd7;

   typedef struct packed {
      logic [3:0]  sel;
      logic [31:0] exp;
   } ent_t;

   ent_t  exp_q[$];
   string name_q[$];
   int    n_chk  = 0;
   int    n_pass = 0;

   dna_csr_regfile dut (
      .clk(clk), .reset(reset), .i_wen(i_wen), .i_addr_w(i_addr_w), .i_data_w(i_data_w),
      .i_addr_r(i_addr_r), .o_data_r(o_data_r), .o_start(o_start), .o_soft_rst(o_soft_rst),
      .o_src_addr(o_src_addr), .o_dst_addr(o_dst_addr), .o_length(o_length),
      .i_done(i_done), .i_err(i_err), .i_result(i_result), .o_busy(o_busy), .o_irq(o_irq)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pick(input logic [3:0] sel);
      case (sel)
         S_RD:    return o_data_r;
         S_START: return {31'd0, o_start};
         S_SOFT:  return {31'd0, o_soft_rst};
         S_BUSY:  return {31'd0, o_busy};
         S_IRQ:   return {31'd0, o_irq};
         S_SRC:   return o_src_addr;
         4'd6:    return o_dst_addr;
         S_LEN:   return o_length;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         ent_t        e;
         string       nm;
         logic [31:0] act;
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         act = pick(e.sel);
         n_chk++;
         if (act === e.exp) n_pass++;
         else $display("FAIL %s: got %08h expected %08h", nm, act, e.exp);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input logic [3:0] sel, input logic [31:0] exp, input string nm);
      exp_q.push_back('{sel: sel, exp: exp});
      name_q.push_back(nm);
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string nm);
      i_addr_r = addr;
      chk(S_RD, exp, nm);
      tick();
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] wen);
      i_addr_w = addr;
      i_data_w = data;
      i_wen    = wen;
      tick();
      i_wen    = 4'h0;
   endtask

   initial begin
      reset = 1'b1; i_wen = '0; i_addr_w = '0; i_data_w = '0; i_addr_r = '0;
      i_done = 1'b0; i_err = 1'b0; i_result = '0;
      tick(); tick();
      chk(S_START, 0, "rst_start"); chk(S_SOFT, 0, "rst_soft");
      chk(S_BUSY, 0, "rst_busy");   chk(S_IRQ, 0, "rst_irq");
      rd(32'h04, 32'h0, "rst_status");
      reset = 1'b0;
      tick();

      // byte strobes, ID, aliasing
      wr(32'h08, 32'h1234_5678, 4'b0101);
      chk(S_SRC, 32'h0034_0078, "src_port");
      rd(32'h08, 32'h0034_0078, "src_strobe");
      rd(32'h0B, 32'h0034_0078, "src_lowbits");
      rd(32'h18, 32'h444E_4101, "id");
      wr(32'h20, 32'h2, 4'b0001);
      rd(32'h00, 32'h2, "ctrl_alias");
      rd(32'h1C, 32'h0, "perf_idle");

      // normal job, RUN for 10 cycles
      wr(32'h10, 32'd16, 4'hF);
      chk(S_LEN, 32'd16, "len_port");
      wr(32'h00, 32'h3, 4'h1);
      chk(S_START, 1, "start_pulse"); chk(S_BUSY, 1, "busy_run");
      tick();
      chk(S_START, 0, "start_once"); chk(S_BUSY, 1, "busy_hold");
      repeat (8) tick();
      i_done = 1'b1; i_result = 32'h0000_CAFE;
      tick();
      i_done = 1'b0; i_result = '0;
      chk(S_BUSY, 0, "busy_fin");
      rd(32'h04, 32'h0, "status_fin");
      chk(S_IRQ, 1, "irq_done");
      rd(32'h04, 32'h2, "status_done");
      rd(32'h14, 32'h0000_CAFE, "result");
      rd(32'h1C, PERF_EXP, "perf_run");
      wr(32'h04, 32'h2, 4'h1);
      chk(S_IRQ, 0, "irq_w1c");
      rd(32'h04, 32'h0, "status_w1c");

      // zero-length job
      wr(32'h10, 32'd0, 4'hF);
      wr(32'h00, 32'h3, 4'h1);
      chk(S_START, 0, "zl_nostart"); chk(S_BUSY, 0, "zl_nobusy");
      rd(32'h04, 32'h0, "zl_status1");
      rd(32'h04, 32'h2, "zl_status2");
      wr(32'h04, 32'hE, 4'h1);

      // start overrun, set-wins against W1C
      wr(32'h10, 32'd4, 4'hF);
      wr(32'h00, 32'h3, 4'h1);
      chk(S_START, 1, "ovr_first");
      tick();
      wr(32'h00, 32'h3, 4'h1);
      chk(S_START, 0, "ovr_nostart"); chk(S_BUSY, 1, "ovr_busy");
      rd(32'h04, 32'h9, "ovr_status");
      i_done = 1'b1; i_result = 32'h0000_BEEF;
      wr(32'h04, 32'h2, 4'h1);
      i_done = 1'b0; i_result = '0;
      chk(S_BUSY, 0, "ovr_fin");
      wr(32'h04, 32'h2, 4'h1);
      chk(S_IRQ, 1, "setwins_irq");
      rd(32'h04, 32'hA, "setwins_status");
      rd(32'h14, 32'h0000_BEEF, "result2");
      wr(32'h04, 32'hE, 4'h1);
      rd(32'h04, 32'h0, "clear_all");

      // stray error pulse outside RUN
      i_err = 1'b1;
      tick();
      i_err = 1'b0;
      rd(32'h04, 32'h4, "stray_err");
      rd(32'h14, 32'h0000_BEEF, "stray_keep_result");
      wr(32'h04, 32'hE, 4'h1);

      // soft reset mid-job
      wr(32'h10, 32'd8, 4'hF);
      wr(32'h00, 32'h3, 4'h1);
      tick();
      wr(32'h00, 32'h6, 4'h1);
      chk(S_SOFT, 1, "soft_pulse"); chk(S_BUSY, 0, "soft_idle");
      tick();
      chk(S_SOFT, 0, "soft_once");
      rd(32'h10, 32'd8, "soft_len_kept");
      wr(32'h00, 32'h7, 4'h1);
      chk(S_START, 0, "soft_beats_start"); chk(S_SOFT, 1, "soft_pulse2");
      chk(S_BUSY, 0, "soft_beats_busy");
      tick();

      // hard reset mid-job with irq pending
      wr(32'h00, 32'h3, 4'h1);
      tick();
      wr(32'h00, 32'h3, 4'h1);
      chk(S_IRQ, 1, "pre_rst_irq");
      reset = 1'b1;
      tick();
      chk(S_BUSY, 0, "hrst_busy"); chk(S_IRQ, 0, "hrst_irq");
      chk(S_START, 0, "hrst_start"); chk(S_SOFT, 0, "hrst_soft");
      chk(S_SRC, 0, "hrst_src"); chk(S_LEN, 0, "hrst_len");
      rd(32'h04, 32'h0, "hrst_status");
      reset = 1'b0;
      rd(32'h00, 32'h0, "hrst_ctrl");
      rd(32'h1C, 32'h0, "hrst_perf");

      tick(); tick();
      n_chk++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
